// File: rtl/sipo_frame_rx.sv
// MSB-first serial-to-parallel frame receiver with a single-entry valid/ready
// output register and sticky overrun / framing-error flags.
module sipo_frame_rx #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         serial_in,
    input  logic         bit_valid,
    input  logic         frame_start,
    input  logic         clr_err,
    input  logic         out_ready,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    output logic         busy,
    output logic         overrun,
    output logic         frame_err
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    logic [N-2:0]    shreg;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // clr_err first so that a flag set later in this block wins
            if (clr_err) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end

            if (data_valid && out_ready)
                data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (bit_valid && frame_start) begin
                        shreg <= (N-1)'(serial_in);
                        cnt   <= CW'(1);
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        if (frame_start) begin
                            frame_err <= 1'b1;
                            shreg     <= (N-1)'(serial_in);
                            cnt       <= CW'(1);
                        end else if (cnt == LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                            if (!data_valid || out_ready) begin
                                data_out   <= {shreg, serial_in};
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            shreg <= (N-1)'({shreg, serial_in});
                            cnt   <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed, table-driven bench for sipo_frame_rx (N=4) with hand-written
// sequences for bit gaps and mid-word reset.
module tb_sipo_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in, bit_valid, frame_start, clr_err, out_ready;
    logic [3:0] data_out;
    logic       data_valid, busy, overrun, frame_err;

    int total = 0;
    int bad   = 0;

    sipo_frame_rx #(.N(4)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .clr_err(clr_err), .out_ready(out_ready),
        .data_out(data_out), .data_valid(data_valid), .busy(busy),
        .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bv, fs, si, rdy, clr;
        logic       dv;
        logic [3:0] dout;
        logic       bsy, ov, fe;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic dv, input logic [3:0] dout,
                           input logic bsy, input logic ov, input logic fe);
        chk({tag, ".data_valid"}, int'(data_valid), int'(dv));
        chk({tag, ".data_out"},   int'(data_out),   int'(dout));
        chk({tag, ".busy"},       int'(busy),       int'(bsy));
        chk({tag, ".overrun"},    int'(overrun),    int'(ov));
        chk({tag, ".frame_err"},  int'(frame_err),  int'(fe));
    endtask

    task automatic cyc(input logic bv, input logic fs, input logic si,
                       input logic rdy, input logic clr, input logic r);
        bit_valid = bv; frame_start = fs; serial_in = si;
        out_ready = rdy; clr_err = clr; rst = r;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic bv, fs, si, rdy, clr, dv,
                                input logic [3:0] dout, input logic bsy, ov, fe);
        vec_t v;
        v.bv = bv; v.fs = fs; v.si = si; v.rdy = rdy; v.clr = clr;
        v.dv = dv; v.dout = dout; v.bsy = bsy; v.ov = ov; v.fe = fe;
        tbl.push_back(v);
    endfunction

    initial begin
        //   bv fs si rdy clr | dv dout  busy ov fe
        // word 1011, consumer ready: valid for exactly one cycle
        add(1, 1, 1, 1, 0,   0, 4'h0, 1, 0, 0);
        add(1, 0, 0, 1, 0,   0, 4'h0, 1, 0, 0);
        add(1, 0, 1, 1, 0,   0, 4'h0, 1, 0, 0);
        add(1, 0, 1, 1, 0,   1, 4'hB, 0, 0, 0);
        add(0, 0, 0, 1, 0,   0, 4'hB, 0, 0, 0);
        // A then 5 back-to-back, consumer stalled -> overrun, A held
        add(1, 1, 1, 0, 0,   0, 4'hB, 1, 0, 0);
        add(1, 0, 0, 0, 0,   0, 4'hB, 1, 0, 0);
        add(1, 0, 1, 0, 0,   0, 4'hB, 1, 0, 0);
        add(1, 0, 0, 0, 0,   1, 4'hA, 0, 0, 0);
        add(1, 1, 0, 0, 0,   1, 4'hA, 1, 0, 0);
        add(1, 0, 1, 0, 0,   1, 4'hA, 1, 0, 0);
        add(1, 0, 0, 0, 0,   1, 4'hA, 1, 0, 0);
        add(1, 0, 1, 0, 0,   1, 4'hA, 0, 1, 0);
        add(0, 0, 0, 1, 0,   0, 4'hA, 0, 1, 0);
        add(0, 0, 0, 0, 0,   0, 4'hA, 0, 1, 0);
        add(0, 0, 0, 0, 1,   0, 4'hA, 0, 0, 0);
        // C held, then 3 completes on the cycle C drains
        add(1, 1, 1, 0, 0,   0, 4'hA, 1, 0, 0);
        add(1, 0, 1, 0, 0,   0, 4'hA, 1, 0, 0);
        add(1, 0, 0, 0, 0,   0, 4'hA, 1, 0, 0);
        add(1, 0, 0, 0, 0,   1, 4'hC, 0, 0, 0);
        add(1, 1, 0, 0, 0,   1, 4'hC, 1, 0, 0);
        add(1, 0, 0, 0, 0,   1, 4'hC, 1, 0, 0);
        add(1, 0, 1, 0, 0,   1, 4'hC, 1, 0, 0);
        add(1, 0, 1, 1, 0,   1, 4'h3, 0, 0, 0);
        add(0, 0, 0, 1, 0,   0, 4'h3, 0, 0, 0);
        // truncated frame 1,1 then 0,1,1,0 -> frame_err, 0110
        add(1, 1, 1, 0, 0,   0, 4'h3, 1, 0, 0);
        add(1, 0, 1, 0, 0,   0, 4'h3, 1, 0, 0);
        add(1, 1, 0, 0, 0,   0, 4'h3, 1, 0, 1);
        add(1, 0, 1, 0, 0,   0, 4'h3, 1, 0, 1);
        add(1, 0, 1, 0, 0,   0, 4'h3, 1, 0, 1);
        add(1, 0, 0, 0, 0,   1, 4'h6, 0, 0, 1);
        add(0, 0, 0, 1, 0,   0, 4'h6, 0, 0, 1);
        // set beats clr in the same cycle; clr alone clears; bv=0 holds state
        add(1, 1, 1, 0, 0,   0, 4'h6, 1, 0, 1);
        add(1, 1, 0, 0, 1,   0, 4'h6, 1, 0, 1);
        add(0, 0, 0, 0, 1,   0, 4'h6, 1, 0, 0);
        add(1, 0, 0, 0, 0,   0, 4'h6, 1, 0, 0);
        add(1, 0, 1, 0, 0,   0, 4'h6, 1, 0, 0);
        add(1, 0, 1, 0, 0,   1, 4'h3, 0, 0, 0);
        add(0, 0, 0, 1, 0,   0, 4'h3, 0, 0, 0);
        // bits without frame_start in IDLE are discarded silently
        add(1, 0, 1, 0, 0,   0, 4'h3, 0, 0, 0);

        // reset state
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk_all("reset", 0, 4'h0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk_all("post_reset", 0, 4'h0, 0, 0, 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].bv, tbl[i].fs, tbl[i].si, tbl[i].rdy, tbl[i].clr, 0);
            chk_all($sformatf("vec%0d", i), tbl[i].dv, tbl[i].dout,
                    tbl[i].bsy, tbl[i].ov, tbl[i].fe);
        end

        // 1011 with idle gaps between every bit; busy held throughout
        begin
            logic [3:0] w;
            w = 4'b1011;
            for (int unsigned b = 0; b < 4; b++) begin
                cyc(1, b == 0, w[3-b], 1, 0, 0);
                if (b < 3) begin
                    chk($sformatf("gap.busy_bit%0d", b), int'(busy), 1);
                    chk($sformatf("gap.dv_bit%0d", b), int'(data_valid), 0);
                    cyc(0, 0, 0, 1, 0, 0);
                    chk($sformatf("gap.busy_idle%0d", b), int'(busy), 1);
                end
            end
            chk_all("gap.done", 1, 4'hB, 0, 0, 0);
            cyc(0, 0, 0, 1, 0, 0);
            chk("gap.drained", int'(data_valid), 0);
        end

        // held word 5 plus partial word, then reset discards both
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        chk_all("rst.held", 1, 4'h5, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        chk("rst.partial_busy", int'(busy), 1);
        cyc(1, 0, 1, 0, 0, 1);
        chk_all("rst.mid", 0, 4'h0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 1, 1, 0, 0);
        chk_all("rst.next", 1, 4'h9, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("rst.next_drained", int'(data_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sipo_frame_rx.md
# sipo_frame_rx

Serial-to-parallel receiver that consumes the MSB-first bit stream produced by the team's parallel-in/serial-out shift stage and reassembles N-bit words. Bits are qualified by a valid strobe and framed by a start marker. Completed words are presented on a single-entry output register with a valid/ready handshake. Sticky flags report dropped words (overrun) and truncated frames (framing error).

## Interface
- N, default 4, word width in bits; legal range N >= 2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- serial_in  in  1  serial data bit, MSB of each word first
- bit_valid  in  1  serial_in is sampled only on cycles where bit_valid=1
- frame_start  in  1  marks the sampled bit as the MSB of a new word; ignored when bit_valid=0
- clr_err  in  1  clears overrun and frame_err (synchronous, one cycle)
- out_ready  in  1  consumer accepts data_out this cycle
- data_out  out  N  assembled word, first received bit in data_out[N-1]
- data_valid  out  1  data_out holds an unconsumed word
- busy  out  1  a word is partially received (state SHIFT)
- overrun  out  1  sticky: a completed word was dropped because the output register was full
- frame_err  out  1  sticky: frame_start arrived before the current word completed

## Operation
- State machine has two states: IDLE and SHIFT. The shift register shreg is N-1 bits wide, bit counter cnt is 0..N-1.
- IDLE: bit_valid=1 with frame_start=1 loads shreg[0]<=serial_in, sets cnt=1, and moves to SHIFT. Bits with frame_start=0 are discarded without error.
- SHIFT, bit_valid=1, frame_start=0, cnt<N-1: shreg<={shreg[N-3:0],serial_in} (left shift), cnt+1.
- SHIFT, bit_valid=1, frame_start=0, cnt==N-1: the word {shreg,serial_in} is complete. The block returns to IDLE and cnt clears.
- SHIFT, bit_valid=1, frame_start=1: the partial word is discarded, frame_err<=1, and the sampled bit becomes the MSB of a new word (cnt=1, stay in SHIFT).
- SHIFT, bit_valid=0: hold all state. There is no timeout.
- Word completion with the output register free (data_valid=0, or data_valid=1 and out_ready=1 in the same cycle): data_out is loaded and data_valid=1.
- Word completion with the output register full and out_ready=0: the word is dropped, overrun<=1, and data_out and data_valid are unchanged.
- Handshake: a transfer happens on any cycle where data_valid=1 and out_ready=1. data_valid falls next cycle unless a new word loads in the same cycle.
- data_out is stable while data_valid=1 and out_ready=0.
- Flag set has priority over clr_err in the same cycle: the flag stays 1.
- busy=1 exactly when state=SHIFT.

## Timing
- Reset values: state=IDLE, cnt=0, shreg=0, data_out=0, data_valid=0, busy=0, overrun=0, frame_err=0.
- Reset mid-word discards the partial word and any held output word.
- Latency: data_valid rises on the clock edge that samples the Nth bit, i.e. visible the cycle after the last bit is presented.
- Throughput: one bit per cycle. Back-to-back words need frame_start on the bit immediately following the completing bit; no idle cycle is required.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- N=4, reset, then bits 1,0,1,1 on consecutive cycles with frame_start on the first and out_ready=1 -> data_out=4'b1011 and data_valid=1 for exactly one cycle, the cycle after the 4th bit.
- Same word with bit_valid=0 gaps between every bit -> same 4'b1011; busy=1 from the first bit until the completing edge.
- Two back-to-back words 4'hA then 4'h5 with out_ready=0 -> data_out stays 4'hA, overrun=1; then out_ready=1 -> 4'hA transferred once. Pulse clr_err -> overrun=0.
- Completion of 4'h3 in the same cycle out_ready=1 drains 4'hC -> data_valid stays 1, data_out=4'h3, overrun=0.
- frame_start after 2 bits (1,1), then bits 0,1,1,0 -> frame_err=1, data_out=4'b0110.
- rst asserted after 2 bits, then a fresh word 4'h9 -> all outputs return to reset values and the next output is 4'h9.
